// File: rtl/fleet_step_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fleet_pkg: shared types and default playfield limits for the fleet stepper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fleet_pkg;
  localparam int FX_W  = 8;
  localparam int FY_W  = 7;
  localparam int TPS_W = 8;

  localparam int X_MIN_DEF  = 0;
  localparam int X_MAX_DEF  = 120;
  localparam int X_STEP_DEF = 2;
  localparam int Y_STEP_DEF = 4;
  localparam int Y_MAX_DEF  = 100;
  localparam int X_INIT_DEF = 0;
  localparam int Y_INIT_DEF = 8;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/fleet_step_ctrl_if.sv
// ---------------------------------------------------------------------------
// fleet_step_ctrl_if: move handshake and fleet anchor towards the draw FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fleet_step_ctrl_if;
  import fleet_pkg::*;

  logic            step_req;
  logic            step_ack;
  logic [FX_W-1:0] fleet_x;
  logic [FY_W-1:0] fleet_y;
  logic            dir_right;
  logic            edge_hit;

  modport master (
    output step_req, fleet_x, fleet_y, dir_right, edge_hit,
    input  step_ack
  );

  modport slave (
    input  step_req, fleet_x, fleet_y, dir_right, edge_hit,
    output step_ack
  );
endinterface

`default_nettype wire

// File: rtl/fleet_step_ctrl_step_timer.sv
// ---------------------------------------------------------------------------
// step_timer: counts qualified frame ticks and pulses due at terminal count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module step_timer
  import fleet_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             tick,
  input  wire logic             enable,
  input  wire logic             hold,
  input  wire logic [TPS_W-1:0] ticks_per_step,
  output logic                  due
);

  logic [TPS_W-1:0] tick_cnt;
  logic [TPS_W:0]   cnt_inc;
  logic [TPS_W:0]   limit;
  logic             qual;

  // A programmed value of 0 behaves as 1 so the fleet never stalls.
  assign limit   = (ticks_per_step == '0) ? {{TPS_W{1'b0}}, 1'b1} : {1'b0, ticks_per_step};
  assign cnt_inc = {1'b0, tick_cnt} + {{TPS_W{1'b0}}, 1'b1};
  assign qual    = tick & enable & ~hold;
  assign due     = qual & (cnt_inc >= limit);

  always_ff @(posedge clk) begin
    if (!reset_n)  tick_cnt <= '0;
    else if (due)  tick_cnt <= '0;
    else if (qual) tick_cnt <= cnt_inc[TPS_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/fleet_step_ctrl.sv
// ---------------------------------------------------------------------------
// fleet_step_ctrl: paces alien-fleet moves and owns anchor position/direction
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fleet_step_ctrl
  import fleet_pkg::*;
#(
  parameter int X_MIN  = X_MIN_DEF,
  parameter int X_MAX  = X_MAX_DEF,
  parameter int X_STEP = X_STEP_DEF,
  parameter int Y_STEP = Y_STEP_DEF,
  parameter int Y_MAX  = Y_MAX_DEF,
  parameter int X_INIT = X_INIT_DEF,
  parameter int Y_INIT = Y_INIT_DEF
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             tick,
  input  wire logic             enable,
  input  wire logic [TPS_W-1:0] ticks_per_step,
  fleet_step_ctrl_if.master     bus,
  output logic                  landed,
  output logic                  overrun
);

  localparam logic [8:0] X_MAX9  = 9'(X_MAX);
  localparam logic [8:0] X_LO9   = 9'(X_MIN + X_STEP);
  localparam logic [8:0] X_STEP9 = 9'(X_STEP);
  localparam logic [8:0] Y_STEP9 = 9'(Y_STEP);
  localparam logic [8:0] Y_MAX9  = 9'(Y_MAX);

  state_t          state, state_next;
  logic            due, commit, descend;
  logic [FX_W-1:0] x_r, x_left, x_new;
  logic [FY_W-1:0] y_r, y_desc, y_new;
  logic [8:0]      x_right, y_sum;
  logic            dir_r, edge_r, ovr_r;

  step_timer u_timer (
    .clk            (clk),
    .reset_n        (reset_n),
    .tick           (tick),
    .enable         (enable),
    .hold           (state != COUNT),
    .ticks_per_step (ticks_per_step),
    .due            (due)
  );

  // Edge tests run in 9 bits so x near 0 or 255 cannot wrap into range.
  assign x_right = {1'b0, x_r} + X_STEP9;
  assign x_left  = x_r - FX_W'(X_STEP);
  assign descend = dir_r ? (x_right > X_MAX9) : ({1'b0, x_r} < X_LO9);
  assign y_sum   = {2'b00, y_r} + Y_STEP9;
  assign y_desc  = (y_sum > 9'd127) ? 7'd127 : y_sum[FY_W-1:0];
  assign x_new   = descend ? x_r : (dir_r ? x_right[FX_W-1:0] : x_left);
  assign y_new   = descend ? y_desc : y_r;
  assign commit  = (state == REQ) & bus.step_ack;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= COUNT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COUNT:   if (due) state_next = REQ;
      REQ:     if (commit) state_next = ({2'b00, y_new} >= Y_MAX9) ? DONE : COUNT;
      DONE:    state_next = DONE;
      default: state_next = COUNT;
    endcase
  end

  always_comb begin
    bus.step_req = (state == REQ);
    landed       = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_r    <= FX_W'(X_INIT);
      y_r    <= FY_W'(Y_INIT);
      dir_r  <= 1'b1;
      edge_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      edge_r <= commit & descend;
      if ((state == REQ) && tick) ovr_r <= 1'b1;
      if (commit) begin
        x_r <= x_new;
        y_r <= y_new;
        if (descend) dir_r <= ~dir_r;
      end
    end
  end

  assign bus.fleet_x   = x_r;
  assign bus.fleet_y   = y_r;
  assign bus.dir_right = dir_r;
  assign bus.edge_hit  = edge_r;
  assign overrun       = ovr_r;

endmodule

`default_nettype wire

// File: tb/tb_fleet_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fleet_step_ctrl: directed self-checking bench for fleet_step_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fleet_step_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] ticks_per_step = 8'd0;
  logic       landed, overrun;
  int         checks = 0;
  int         errors = 0;

  fleet_step_ctrl_if bus ();

  fleet_step_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tick           (tick),
    .enable         (enable),
    .ticks_per_step (ticks_per_step),
    .bus            (bus),
    .landed         (landed),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  // One full move: tick, wait for the request, acknowledge it.
  task automatic do_move(output bit ok);
    ok = 1'b0;
    pulse_tick();
    for (int i = 0; i < 8 && !ok; i++) begin
      if (bus.step_req === 1'b1) ok = 1'b1;
      else cyc(1);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL move_timeout: step_req never rose (x=%0d y=%0d)", bus.fleet_x, bus.fleet_y);
      return;
    end
    bus.step_ack = 1'b1;
    cyc(1);
    bus.step_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.step_ack = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    checks++;
    if ({bus.step_req, bus.fleet_x, bus.fleet_y, bus.dir_right, bus.edge_hit, landed, overrun}
        !== {1'b0, 8'd0, 7'd8, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: req=%0b x=%0d y=%0d dir=%0b edge=%0b landed=%0b ovr=%0b, want 0 0 8 1 0 0 0",
               bus.step_req, bus.fleet_x, bus.fleet_y, bus.dir_right, bus.edge_hit, landed, overrun);
    end
  endtask

  task automatic test_count3();
    ticks_per_step = 8'd3;
    enable = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      pulse_tick();
      checks++;
      if (bus.step_req !== (t == 3)) begin
        errors++;
        $display("FAIL count3_tick%0d: step_req=%0b want %0b", t, bus.step_req, (t == 3));
      end
      if (t < 3) cyc(9);
    end
    bus.step_ack = 1'b1;
    cyc(1);
    bus.step_ack = 1'b0;
    checks++;
    if ({bus.fleet_x, bus.fleet_y, bus.step_req} !== {8'd2, 7'd8, 1'b0}) begin
      errors++;
      $display("FAIL count3_ack: x=%0d y=%0d req=%0b want 2 8 0", bus.fleet_x, bus.fleet_y, bus.step_req);
    end
  endtask

  task automatic test_tps_zero_and_enable();
    bit ok;
    int bad;
    ticks_per_step = 8'd0;
    do_move(ok);
    checks++;
    if (bus.fleet_x !== 8'd4) begin
      errors++;
      $display("FAIL tps0_move: x=%0d want 4", bus.fleet_x);
    end
    // Partial count of 1, then five frozen ticks must not advance it.
    ticks_per_step = 8'd3;
    pulse_tick();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      if (bus.step_req !== 1'b0) bad++;
      cyc(2);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL enable_off: step_req seen %0d times want 0", bad);
    end
    enable = 1'b1;
    pulse_tick();
    checks++;
    if (bus.step_req !== 1'b0) begin
      errors++;
      $display("FAIL cnt_held: step_req=%0b after 2nd counted tick want 0", bus.step_req);
    end
    pulse_tick();
    checks++;
    if (bus.step_req !== 1'b1) begin
      errors++;
      $display("FAIL cnt_held_due: step_req=%0b after 3rd counted tick want 1", bus.step_req);
    end
    bus.step_ack = 1'b1;
    cyc(1);
    bus.step_ack = 1'b0;
  endtask

  task automatic test_overrun();
    ticks_per_step = 8'd1;
    pulse_tick();
    cyc(1);
    pulse_tick();
    pulse_tick();
    checks++;
    if ({overrun, bus.step_req, bus.fleet_x} !== {1'b1, 1'b1, 8'd6}) begin
      errors++;
      $display("FAIL overrun_set: ovr=%0b req=%0b x=%0d want 1 1 6", overrun, bus.step_req, bus.fleet_x);
    end
    tick = 1'b1;
    bus.step_ack = 1'b1;
    cyc(1);
    tick = 1'b0;
    bus.step_ack = 1'b0;
    checks++;
    if ({bus.fleet_x, bus.step_req, overrun} !== {8'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL tick_ack_same: x=%0d req=%0b ovr=%0b want 8 0 1", bus.fleet_x, bus.step_req, overrun);
    end
    cyc(3);
    checks++;
    if ({bus.fleet_x, bus.step_req, overrun} !== {8'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_commit: x=%0d req=%0b ovr=%0b want 8 0 1", bus.fleet_x, bus.step_req, overrun);
    end
  endtask

  task automatic test_edges();
    bit ok = 1'b1;
    ticks_per_step = 8'd0;
    for (int i = 0; i < 200 && ok && bus.fleet_x !== 8'd120; i++) do_move(ok);
    do_move(ok);
    checks++;
    if ({bus.fleet_x, bus.fleet_y, bus.dir_right, bus.edge_hit} !== {8'd120, 7'd12, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL right_edge: x=%0d y=%0d dir=%0b edge=%0b want 120 12 0 1",
               bus.fleet_x, bus.fleet_y, bus.dir_right, bus.edge_hit);
    end
    cyc(1);
    checks++;
    if (bus.edge_hit !== 1'b0) begin
      errors++;
      $display("FAIL edge_pulse_len: edge_hit=%0b want 0", bus.edge_hit);
    end
    do_move(ok);
    checks++;
    if ({bus.fleet_x, bus.edge_hit} !== {8'd118, 1'b0}) begin
      errors++;
      $display("FAIL after_right_edge: x=%0d edge=%0b want 118 0", bus.fleet_x, bus.edge_hit);
    end
    for (int i = 0; i < 200 && ok && bus.fleet_x !== 8'd0; i++) do_move(ok);
    do_move(ok);
    checks++;
    if ({bus.fleet_x, bus.fleet_y, bus.dir_right, bus.edge_hit} !== {8'd0, 7'd16, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL left_edge: x=%0d y=%0d dir=%0b edge=%0b want 0 16 1 1",
               bus.fleet_x, bus.fleet_y, bus.dir_right, bus.edge_hit);
    end
  endtask

  task automatic test_landing();
    bit ok = 1'b1;
    int bad = 0;
    for (int i = 0; i < 3000 && ok && bus.fleet_y !== 7'd96; i++) do_move(ok);
    for (int i = 0; i < 200 && ok && bus.fleet_y === 7'd96; i++) do_move(ok);
    checks++;
    if ({bus.fleet_y, landed, bus.step_req} !== {7'd100, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL landing: y=%0d landed=%0b req=%0b want 100 1 0", bus.fleet_y, landed, bus.step_req);
    end
    for (int i = 0; i < 20; i++) begin
      pulse_tick();
      if (bus.step_req !== 1'b0 || landed !== 1'b1) bad++;
      cyc(1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL done_ignores_ticks: %0d bad cycles want 0", bad);
    end
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    checks++;
    if ({bus.fleet_x, bus.fleet_y, landed, overrun, bus.dir_right} !== {8'd0, 7'd8, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_after_land: x=%0d y=%0d landed=%0b ovr=%0b dir=%0b want 0 8 0 0 1",
               bus.fleet_x, bus.fleet_y, landed, overrun, bus.dir_right);
    end
  endtask

  task automatic test_reset_mid_handshake();
    ticks_per_step = 8'd0;
    pulse_tick();
    checks++;
    if (bus.step_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_hs_req: step_req=%0b want 1", bus.step_req);
    end
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    checks++;
    if ({bus.step_req, bus.fleet_x} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_hs_reset: req=%0b x=%0d want 0 0", bus.step_req, bus.fleet_x);
    end
  endtask

  initial begin
    bus.step_ack = 1'b0;
    test_reset();
    test_count3();
    test_tps_zero_and_enable();
    test_overrun();
    test_edges();
    test_landing();
    test_reset_mid_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fleet_step_ctrl.md
Name: fleet_step_ctrl

Overview:
Consumer end of the frame-tick interface. Takes the single-cycle tick pulses from the frame-rate divider, counts a programmable number of ticks per fleet move, and requests each move from the draw FSM with a req/ack handshake. Owns the alien-fleet anchor position (x, y) and horizontal direction. Reverses direction and steps down at the screen edges, and flags landing when the fleet reaches the bottom limit.

Parameters:
X_MIN, 0, leftmost legal anchor x
X_MAX, 120, rightmost legal anchor x
X_STEP, 2, horizontal pixels per move
Y_STEP, 4, vertical pixels per edge descent
Y_MAX, 100, landing row; y >= Y_MAX ends play
X_INIT, 0, anchor x after reset
Y_INIT, 8, anchor y after reset

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  reset: synchronous, active-low; clock clk
tick  in  1  one-cycle frame tick from the rate divider
enable  in  1  1 = game running; 0 = freeze tick counting
ticks_per_step  in  8  frame ticks per move; 0 is treated as 1
step_req  out  1  move pending; held until step_ack
step_ack  in  1  draw FSM has erased the fleet; commit the move
fleet_x  out  8  current anchor x
fleet_y  out  7  current anchor y
dir_right  out  1  1 = moving right
edge_hit  out  1  one-cycle pulse on the cycle a descent is committed
landed  out  1  sticky; fleet reached Y_MAX
overrun  out  1  sticky; a tick arrived while step_req was pending

Behaviour:
- Reset values (reset_n = 0 sampled on a clk edge): state COUNT, tick_cnt 0, fleet_x X_INIT, fleet_y Y_INIT, dir_right 1, step_req 0, edge_hit 0, landed 0, overrun 0.
- Reset has priority over every other input. Reset mid-handshake drops step_req on the next edge.
- States:
  - COUNT: step_req = 0. On tick & enable:
    - if tick_cnt + 1 >= max(ticks_per_step, 1): tick_cnt <= 0, go to REQ.
    - else tick_cnt <= tick_cnt + 1.
    - tick with enable = 0 is ignored; tick_cnt is held.
  - REQ: step_req = 1 (registered output, asserted the cycle after entry).
    - tick is not counted and sets overrun.
    - step_ack commits the move on that edge (see move rules).
    - Next state is DONE if the new y >= Y_MAX, else COUNT.
    - Deasserting enable does not withdraw the request.
  - DONE: step_req = 0, landed = 1. Ticks are ignored. Exit only via reset.
- step_ack outside REQ is ignored.
- tick and step_ack in the same REQ cycle: the move commits, overrun is set, and the tick is not counted.
- Move rules on commit (compute in 9-bit unsigned to avoid wrap):
  - Moving right: if fleet_x + X_STEP > X_MAX, descend. Otherwise fleet_x += X_STEP.
  - Moving left: if fleet_x < X_MIN + X_STEP, descend. Otherwise fleet_x -= X_STEP.
  - Descend: fleet_y += Y_STEP (saturate at 127), toggle dir_right, hold fleet_x, pulse edge_hit for exactly one cycle.
- Latency: from the qualifying tick to step_req = 1 is 1 cycle. From step_ack to updated fleet_x/fleet_y is visible the next cycle, and step_req = 0 the same next cycle.
- ticks_per_step is sampled each tick. A change while counting takes effect on the next comparison; if tick_cnt already exceeds the new value, the next tick triggers a move.

Decomposition:
- Package fleet_pkg holds:
  - state enum {COUNT, REQ, DONE}
  - width constants FX_W = 8, FY_W = 7, TPS_W = 8
  - default X/Y limits shared with the draw FSM
- One sub-module, step_timer: tick qualification, tick_cnt, and terminal-count compare. It outputs a single-cycle "due" pulse and takes a hold input driven while in REQ/DONE. The parent holds the FSM, position, and handshake.

Test Plan:
- Reset, ticks_per_step = 3, enable = 1, 3 ticks 10 cycles apart:
  - step_req rises 1 cycle after the 3rd tick, not before.
  - ack → fleet_x = 2, fleet_y = 8, step_req = 0 the next cycle.
- ticks_per_step = 0: every tick produces step_req. enable = 0 with 5 ticks: no step_req, and tick_cnt is held.
- Start fleet_x = 120 moving right, ack a move:
  - fleet_x = 120, fleet_y = 12, dir_right = 0, edge_hit high for exactly 1 cycle.
  - Next move gives fleet_x = 118.
- Leftmost fleet_x = 0 moving left, ack: fleet_y += 4, dir_right = 1, fleet_x stays 0 (no underflow to 254).
- Hold step_ack low while 2 ticks arrive: overrun = 1 and stays 1. Simultaneous tick + ack commits exactly one move.
- fleet_y = 96, descend:
  - fleet_y = 100, landed = 1, state DONE, no further step_req for 20 ticks.
  - reset_n low for one edge restores x = 0, y = 8, landed = 0.
